// File: rtl/uart_tx_frame.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_frame                                                |
// | Description : UART transmitter. Takes one word per valid/ready handshake   |
// |               and sends it LSB-first as a frame:                           |
// |               start bit, DATA_BITS data bits, optional parity bit,         |
// |               then STOP_BITS stop bits.                                    |
// |               Every bit lasts CLK_DIV clocks.                              |
// |               A handshake taken in the last stop-bit cycle starts the      |
// |               next frame with no idle gap.                                 |
// |               Optional feature macro: UART_TX_PARITY_EN adds a parity bit  |
// |               whose sense is selected by PARITY_ODD (0 even, 1 odd).       |
// | Ports       : clk        system clock, posedge                             |
// |               rst_n      asynchronous active-low reset                     |
// |               axi_valid  source presents a word on axi_data               |
// |               axi_ready  block accepts a word this cycle (registered)      |
// |               axi_data   word to send, sampled only on handshake           |
// |               uart_tx    serial line, idles high (registered)              |
// |               busy       high while a frame is on the line                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx_frame #(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 axi_valid,
    output logic                 axi_ready,
    input  logic [DATA_BITS-1:0] axi_data,
    output logic                 uart_tx,
    output logic                 busy
);

    localparam int c_CW = $clog2(CLK_DIV);
    localparam int c_BW = $clog2(DATA_BITS);

    localparam logic [c_CW-1:0] c_BAUD_LOAD = c_CW'(CLK_DIV - 1);
    localparam logic [c_CW-1:0] c_BAUD_ONE  = c_CW'(1);
    localparam logic [c_BW-1:0] c_LAST_BIT  = c_BW'(DATA_BITS - 1);
    localparam logic [c_BW-1:0] c_BIT_ONE   = c_BW'(1);
    localparam logic            c_LAST_STOP = 1'(STOP_BITS - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic       c_ODD    = (PARITY_ODD != 0);
`endif
    localparam logic [2:0] c_STOP   = 3'd4;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (CLK_DIV < 2) begin : g_bad_clk_div
            $error("uart_tx_frame: CLK_DIV must be >= 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_frame: DATA_BITS must be in 5..9");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx_frame: STOP_BITS must be 1 or 2");
        end
        if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
            $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [2:0]           r_state;
    logic [c_CW-1:0]      r_baud;
    logic [c_BW-1:0]      r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_ready;
    logic                 r_tx;
    logic                 r_busy;

    logic [2:0]           w_state_nx;
    logic [c_CW-1:0]      w_baud_nx;
    logic [c_BW-1:0]      w_bit_nx;
    logic                 w_stop_nx;
    logic [DATA_BITS-1:0] w_shift_nx;
    logic                 w_ready_nx;
    logic                 w_tx_nx;
    logic                 w_hs;
    logic                 w_bit_end;

`ifdef UART_TX_PARITY_EN
    logic                 r_par;
    logic                 w_par_nx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_ready    <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_baud     <= w_baud_nx;
            r_bit_idx  <= w_bit_nx;
            r_stop_idx <= w_stop_nx;
            r_shift    <= w_shift_nx;
            r_ready    <= w_ready_nx;
            r_tx       <= w_tx_nx;
            r_busy     <= (w_state_nx != c_IDLE);
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else begin
            r_par <= w_par_nx;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_hs       = axi_valid && r_ready;
        w_bit_end  = (r_baud == '0);
        w_state_nx = r_state;
        w_baud_nx  = w_bit_end ? c_BAUD_LOAD : (r_baud - c_BAUD_ONE);
        w_bit_nx   = r_bit_idx;
        w_stop_nx  = r_stop_idx;
        w_shift_nx = r_shift;
`ifdef UART_TX_PARITY_EN
        w_par_nx   = r_par;
`endif

        // r_ready is only high in IDLE or the final stop cycle, so a
        // handshake can only land where a new frame is allowed to begin.
        if (w_hs) begin
            w_shift_nx = axi_data;
`ifdef UART_TX_PARITY_EN
            w_par_nx   = (^axi_data) ^ c_ODD;
`endif
        end

        case (r_state)
            c_IDLE: begin
                w_baud_nx = c_BAUD_LOAD;
                if (w_hs) begin
                    w_state_nx = c_START;
                end
            end
            c_START: begin
                if (w_bit_end) begin
                    w_state_nx = c_DATA;
                    w_bit_nx   = '0;
                end
            end
            c_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == c_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nx = c_PARITY;
`else
                        w_state_nx = c_STOP;
                        w_stop_nx  = 1'b0;
`endif
                    end else begin
                        w_shift_nx = {1'b0, r_shift[DATA_BITS-1:1]};
                        w_bit_nx   = r_bit_idx + c_BIT_ONE;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            c_PARITY: begin
                if (w_bit_end) begin
                    w_state_nx = c_STOP;
                    w_stop_nx  = 1'b0;
                end
            end
`endif
            c_STOP: begin
                if (w_bit_end) begin
                    if (r_stop_idx == c_LAST_STOP) begin
                        w_state_nx = w_hs ? c_START : c_IDLE;
                    end else begin
                        w_stop_nx = r_stop_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = c_IDLE;
            end
        endcase

        // Ready is registered, so it is decided from where the FSM will be
        // next cycle: idle, or sitting in the last count of the last stop bit.
        w_ready_nx = (w_state_nx == c_IDLE) ||
                     ((w_state_nx == c_STOP) && (w_stop_nx == c_LAST_STOP) &&
                      (w_baud_nx == '0));

        // Line level is registered from the next state so the pin is
        // glitch-free and the start bit appears the cycle after handshake.
        case (w_state_nx)
            c_START:  w_tx_nx = 1'b0;
            c_DATA:   w_tx_nx = w_shift_nx[0];
`ifdef UART_TX_PARITY_EN
            c_PARITY: w_tx_nx = w_par_nx;
`endif
            default:  w_tx_nx = 1'b1;
        endcase
    end

    assign axi_ready = r_ready;
    assign uart_tx   = r_tx;
    assign busy      = r_busy;

endmodule
`default_nettype wire
